prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter IR_width, default 12, meaning instruction word width written to instruction memory.
REQ-002 The block SHALL have parameter Im_width, default 8, meaning instruction memory address width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load_req  input  1  request to begin a program load; sampled each cycle.
REQ-006 The block SHALL have port byte_in  input  8  serial program byte.
REQ-007 The block SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-008 The block SHALL have port byte_ready  output  1  block accepts byte_in this cycle.
REQ-009 The block SHALL have port im_address  output  Im_width  instruction memory write address.
REQ-010 The block SHALL have port im_data  output  IR_width  instruction memory write data.
REQ-011 The block SHALL have port im_wren  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-012 The block SHALL have port start  output  1  processor start; held high after a successful load.
REQ-013 The block SHALL have port busy  output  1  load in progress (any state other than IDLE, DONE, ERR).
REQ-014 The block SHALL have port error  output  1  last load aborted on a format error.

Function
REQ-015 The block SHALL implement states IDLE, HDR, LO, HI, WRITE, DONE, ERR.
REQ-016 A byte SHALL transfer only on a rising edge where byte_valid and byte_ready are both 1; byte_ready SHALL be 1 exactly in HDR, LO and HI.
REQ-017 IDLE, DONE, ERR: load_req=1 SHALL move to HDR, clear start, error, word counter and address counter; load_req SHALL be ignored in all other states.
REQ-018 HDR: the accepted byte SHALL set word count N, value 0 meaning 2^Im_width (256 at default); then LO.
REQ-019 LO: the accepted byte SHALL become im_data[7:0]; then HI.
REQ-020 HI: byte bits [3:0] SHALL become im_data[11:8]; bits [7:4] nonzero SHALL go to ERR without writing; otherwise WRITE.
REQ-021 WRITE: im_wren SHALL be 1 for exactly this one cycle with im_address = address counter and im_data stable; the address counter SHALL then increment modulo 2^Im_width.
REQ-022 After WRITE, the block SHALL go to DONE if N words are written, else to LO.
REQ-023 Write latency SHALL be one cycle: im_wren is high in the cycle after the HI byte is accepted.
REQ-024 The first word SHALL go to address 0; with N=0 (256 words) the last write SHALL be at address 255 and the counter SHALL wrap to 0 with no extra write.
REQ-025 DONE: start SHALL be 1 and held until reset or a new load_req.
REQ-026 ERR: error SHALL be 1 and start 0; words already written SHALL remain in memory.
REQ-027 byte_valid low in HDR/LO/HI SHALL stall the FSM indefinitely with no timeout.
REQ-028 im_wren SHALL be 0 in every state except WRITE.

Reset
REQ-029 reset=0 SHALL immediately, independent of clk, force IDLE with byte_ready, im_address, im_data, im_wren, start, busy, error and all counters at 0.
REQ-030 Reset asserted mid-load SHALL abort without completing a pending write; the next load SHALL restart at address 0.

Verification
REQ-031 Bytes 0x02,0x34,0x01,0xFF,0x0A after load_req -> writes 0x134@0, 0xAFF@1; start=1 after the second write; error=0.
REQ-032 Header 0x01, bytes 0x55,0x30 -> no im_wren; error=1, start=0, state ERR; a later load_req clears error.
REQ-033 Header 0x00, 512 data bytes -> 256 writes at addresses 0..255, then start=1, im_address wraps to 0.
REQ-034 byte_valid low for 10 cycles between the LO and HI bytes -> byte_ready remains 1, no write until the HI byte is accepted, written data correct.
REQ-035 reset pulled low in the cycle after a HI byte is accepted -> im_wren=0, all outputs 0; after release, a 1-word load writes to address 0.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: takes a header byte (word count) followed by lo/hi byte
// pairs and writes each assembled word to instruction memory, then raises start.
//
// state | meaning
// IDLE  | waiting for the first load_req after reset
// HDR   | accepting the word-count byte (0 means 2^Im_width)
// LO    | accepting the low data byte
// HI    | accepting the high data byte, checking its unused bits
// WRITE | single-cycle instruction memory write
// DONE  | all words written, start held high
// ERR   | load aborted on a malformed high byte
module prog_loader #(
  parameter int IR_width = 12,
  parameter int Im_width = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [Im_width-1:0] im_address,
  output logic [IR_width-1:0] im_data,
  output logic                im_wren,
  output logic                start,
  output logic                busy,
  output logic                error
);

  localparam int CW = ((Im_width > 8) ? Im_width : 8) + 1;

  typedef enum logic [2:0] {IDLE, HDR, LO, HI, WRITE, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] words_left;
  logic [CW-1:0] hdr_count;
  logic          accept;
  logic          hi_bad;

  assign accept = byte_valid & byte_ready;

  always_comb begin
    hdr_count = CW'(byte_in);
    if (byte_in == 8'd0) hdr_count = CW'(1) << Im_width;
    // High byte may only carry the bits that fit above the low byte.
    hi_bad = (byte_in >> (IR_width - 8)) != 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      im_address <= '0;
      im_data    <= '0;
      im_wren    <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      words_left <= '0;
    end else begin
      im_wren <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (load_req) begin
            state      <= HDR;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            start      <= 1'b0;
            error      <= 1'b0;
            words_left <= '0;
            im_address <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            words_left <= hdr_count;
            state      <= LO;
          end
        end
        LO: begin
          if (accept) begin
            im_data[7:0] <= byte_in;
            state        <= HI;
          end
        end
        HI: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (hi_bad) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              im_data[IR_width-1:8] <= byte_in[IR_width-9:0];
              im_wren               <= 1'b1;
              state                 <= WRITE;
            end
          end
        end
        WRITE: begin
          im_address <= im_address + Im_width'(1);
          words_left <= words_left - CW'(1);
          if (words_left == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            start <= 1'b1;
          end else begin
            state      <= LO;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal load, format error, 256-word wrap,
// stalled byte stream and reset during a pending write.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  im_address;
  logic [11:0] im_data;
  logic        im_wren;
  logic        start;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  // write log filled by the monitor below
  logic [7:0]  wr_addr [0:1023];
  logic [11:0] wr_data [0:1023];
  int          wr_total = 0;

  prog_loader #(.IR_width(12), .Im_width(8)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .im_address(im_address),
    .im_data(im_data), .im_wren(im_wren), .start(start), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_wren && wr_total < 1024) begin
      wr_addr[wr_total] = im_address;
      wr_data[wr_total] = im_data;
      wr_total = wr_total + 1;
    end
  end

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1 (byte %h)", byte_ready, b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({byte_ready, im_address, im_data, im_wren, start, busy, error} !== 25'd0) begin
      errors++;
      $display("FAIL %s: rdy=%b addr=%h data=%h wren=%b start=%b busy=%b err=%b required all 0",
               tag, byte_ready, im_address, im_data, im_wren, start, busy, error);
    end
  endtask

  task automatic check_write(input int idx, input logic [7:0] a, input logic [11:0] d, input string tag);
    checks++;
    if (wr_addr[idx] !== a || wr_data[idx] !== d) begin
      errors++;
      $display("FAIL %s: write %0d got %h@%h required %h@%h", tag, idx, wr_data[idx], wr_addr[idx], d, a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    int base;
    base = wr_total;
    pulse_load();
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_hdr: busy=%b rdy=%b required 1 1", busy, byte_ready);
    end
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h01);
    checks++;
    if (im_wren !== 1'b1 || im_address !== 8'h00 || im_data !== 12'h134) begin
      errors++;
      $display("FAIL basic_latency: wren=%b addr=%h data=%h required 1 00 134", im_wren, im_address, im_data);
    end
    send_byte(8'hFF);
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL basic_start_early: start=%b required 0", start);
    end
    send_byte(8'h0A);
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 || im_wren !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: start=%b err=%b busy=%b rdy=%b wren=%b required 1 0 0 0 0",
               start, error, busy, byte_ready, im_wren);
    end
    checks++;
    if (wr_total - base !== 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required 2", wr_total - base);
    end
    check_write(base, 8'h00, 12'h134, "basic_w0");
    check_write(base + 1, 8'h01, 12'hAFF, "basic_w1");
    repeat (3) @(negedge clk);
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL basic_start_held: start=%b required 1", start);
    end
  endtask

  task automatic test_format_error();
    int base;
    base = wr_total;
    pulse_load();
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL err_start_cleared: start=%b required 0", start);
    end
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h30);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 || im_wren !== 1'b0) begin
      errors++;
      $display("FAIL err_state: err=%b start=%b busy=%b rdy=%b wren=%b required 1 0 0 0 0",
               error, start, busy, byte_ready, im_wren);
    end
    checks++;
    if (wr_total !== base) begin
      errors++;
      $display("FAIL err_no_write: got %0d writes required 0", wr_total - base);
    end
    pulse_load();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_cleared: err=%b busy=%b required 0 1", error, busy);
    end
    send_byte(8'h01);
    send_byte(8'hC3);
    send_byte(8'h0F);
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || wr_total - base !== 1) begin
      errors++;
      $display("FAIL err_reload: start=%b writes=%0d required 1 1", start, wr_total - base);
    end
    check_write(base, 8'h00, 12'hFC3, "err_reload_w0");
  endtask

  task automatic test_full_256();
    int base;
    logic [7:0] lo;
    logic [7:0] hi;
    base = wr_total;
    pulse_load();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i) ^ 8'h5A;
      hi = {4'h0, 4'(i)};
      if (i == 255) begin
        checks++;
        if (start !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL full_not_done_early: start=%b busy=%b required 0 1", start, busy);
        end
      end
      send_byte(lo);
      send_byte(hi);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || im_address !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done: start=%b addr=%h busy=%b required 1 00 0", start, im_address, busy);
    end
    checks++;
    if (wr_total - base !== 256) begin
      errors++;
      $display("FAIL full_count: got %0d required 256", wr_total - base);
    end
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i) ^ 8'h5A;
      check_write(base + i, 8'(i), {4'(i), lo}, "full_word");
    end
  endtask

  task automatic test_stall();
    int base;
    base = wr_total;
    pulse_load();
    send_byte(8'h01);
    send_byte(8'hAB);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (byte_ready !== 1'b1 || im_wren !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: rdy=%b wren=%b required 1 0", i, byte_ready, im_wren);
      end
      @(negedge clk);
    end
    checks++;
    if (wr_total !== base) begin
      errors++;
      $display("FAIL stall_no_write: got %0d writes required 0", wr_total - base);
    end
    send_byte(8'h07);
    @(negedge clk);
    checks++;
    if (wr_total - base !== 1 || start !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: writes=%0d start=%b required 1 1", wr_total - base, start);
    end
    check_write(base, 8'h00, 12'h7AB, "stall_w0");
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_total;
    pulse_load();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h02);
    checks++;
    if (im_wren !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending_write: wren=%b required 1", im_wren);
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_async_reset");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wr_total !== base) begin
      errors++;
      $display("FAIL mid_no_write: got %0d writes required 0", wr_total - base);
    end
    reset = 1'b1;
    @(negedge clk);
    base = wr_total;
    pulse_load();
    send_byte(8'h01);
    send_byte(8'h22);
    send_byte(8'h03);
    @(negedge clk);
    checks++;
    if (wr_total - base !== 1 || start !== 1'b1) begin
      errors++;
      $display("FAIL mid_reload: writes=%0d start=%b required 1 1", wr_total - base, start);
    end
    check_write(base, 8'h00, 12'h322, "mid_reload_w0");
  endtask

  initial begin
    reset      = 1'b0;
    load_req   = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_format_error();
    test_full_256();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
